// File: rtl/lightsout_pkg.sv
// Shared constants, key index type and index helper for the lights-out keypad front-end.
package lightsout_pkg;

  localparam int unsigned KP_ROWS   = 3;
  localparam int unsigned KP_COLS   = 3;
  localparam int unsigned NKEYS     = KP_ROWS * KP_COLS;
  localparam int unsigned KEY_IDX_W = 4;

  typedef logic [KEY_IDX_W-1:0] key_idx_t;

  function automatic key_idx_t idx_of(input int unsigned row, input int unsigned col,
                                      input int unsigned ncols = KP_COLS);
    return key_idx_t'(row * ncols + col);
  endfunction

endpackage

// File: rtl/lightsout_debounce_cell.sv
// Per-key debouncer: the level flips after DB_COUNT consecutive samples that disagree with it.
module lightsout_debounce_cell #(
  parameter int unsigned DB_COUNT = 16
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic sample_en,
  input  logic sample,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DB_COUNT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          flip;

  assign flip = sample_en && (sample != level_q) && (cnt_q == CW'(DB_COUNT - 1));

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sample_en) begin
      if (sample == level_q) begin
        cnt_d = '0;
      end else if (flip) begin
        cnt_d   = '0;
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign rise  = flip && !level_q;

endmodule

// File: rtl/lightsout_key_scanner.sv
// Keypad scanner: column drive, row sync, per-key debounce, press queue and valid/ready output.
// Define LIGHTSOUT_KEY_REPEAT_EN to add per-key auto-repeat while a key stays held.
module lightsout_key_scanner
  import lightsout_pkg::*;
#(
  parameter int unsigned NROWS        = KP_ROWS,
  parameter int unsigned NCOLS        = KP_COLS,
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned DB_COUNT     = 16,
  parameter int unsigned REPEAT_SCANS = 64
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [NROWS-1:0]       row_in,
  output logic [NCOLS-1:0]       col_out,
  output logic                   key_valid,
  output logic [KEY_IDX_W-1:0]   key_idx,
  input  logic                   key_ready,
  input  logic                   flush,
  output logic [NROWS*NCOLS-1:0] key_state,
  output logic                   overflow
);

  localparam int unsigned NUM_KEYS = NROWS * NCOLS;
  localparam int unsigned DW       = $clog2(SCAN_DIV);
  localparam int unsigned CLW      = (NCOLS > 1) ? $clog2(NCOLS) : 1;

  logic [DW-1:0]       dwell_q;
  logic [CLW-1:0]      col_q;
  logic                dwell_end, frame_end;
  logic [NROWS-1:0]    row_meta_q, row_sync_q;
  logic [NUM_KEYS-1:0] level, rise, press;
  logic [NUM_KEYS-1:0] pend_q, pend_d, sel_oh;
  logic [KEY_IDX_W-1:0] idx_q, idx_d, sel;
  logic                valid_q, valid_d, ovf_q, ovf_d;
  logic                any, load, take;

  assign dwell_end = (dwell_q == DW'(SCAN_DIV - 1));
  assign frame_end = dwell_end && (col_q == CLW'(NCOLS - 1));

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      dwell_q <= '0;
      col_q   <= '0;
    end else if (dwell_end) begin
      dwell_q <= '0;
      col_q   <= frame_end ? '0 : col_q + 1'b1;
    end else begin
      dwell_q <= dwell_q + 1'b1;
    end
  end

  // Synchroniser is free-running; its two-cycle lag stays inside the column dwell.
  always_ff @(posedge CLK) begin
    row_meta_q <= row_in;
    row_sync_q <= row_meta_q;
  end

  assign col_out = NCOLS'(1) << col_q;

  for (genvar r = 0; r < NROWS; r++) begin : g_row
    for (genvar c = 0; c < NCOLS; c++) begin : g_col
      localparam int unsigned K = idx_of(r, c, NCOLS);
      lightsout_debounce_cell #(
        .DB_COUNT(DB_COUNT)
      ) u_cell (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .sample_en(dwell_end && (col_q == CLW'(c))),
        .sample   (row_sync_q[r]),
        .level    (level[K]),
        .rise     (rise[K])
      );
    end
  end

`ifdef LIGHTSOUT_KEY_REPEAT_EN
  localparam int unsigned RW = $clog2(REPEAT_SCANS + 1);
  logic [NUM_KEYS-1:0][RW-1:0] rep_q;
  logic [NUM_KEYS-1:0]         rep_fire;

  always_comb begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      rep_fire[k] = level[k] && frame_end && (rep_q[k] == RW'(REPEAT_SCANS - 1));
    end
  end

  always_ff @(posedge CLK) begin
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (!RESET_N || !level[k]) begin
        rep_q[k] <= '0;
      end else if (frame_end) begin
        rep_q[k] <= rep_fire[k] ? '0 : rep_q[k] + 1'b1;
      end
    end
  end

  assign press = rise | rep_fire;
`else
  assign press = rise;
`endif

  always_comb begin
    sel    = '0;
    sel_oh = '0;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pend_q[k]) begin
        sel    = KEY_IDX_W'(k);
        sel_oh = NUM_KEYS'(1) << k;
      end
    end
  end

  assign any  = |pend_q;
  assign load = !valid_q || key_ready;
  assign take = load && any;

  always_comb begin
    pend_d  = pend_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    ovf_d   = ovf_q;
    if (flush) begin
      pend_d  = '0;
      valid_d = 1'b0;
    end else begin
      if (load) begin
        valid_d = any;
        if (any) begin
          idx_d  = sel;
          pend_d = pend_q & ~sel_oh;
        end
      end
      // A press landing on the bit being handed out re-arms it without counting as overflow.
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (press[k]) begin
          if (pend_q[k] && !(take && sel_oh[k])) ovf_d = 1'b1;
          pend_d[k] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
      ovf_q   <= ovf_d;
    end
  end

  assign key_valid = valid_q;
  assign key_idx   = idx_q;
  assign key_state = level;
  assign overflow  = ovf_q;

endmodule
